// File: rtl/lite_nasti_reader.sv
// Bridges one lite read at a time onto a NASTI read burst and packs the
// returned beats (narrow lanes or a wide slice) into a single lite response.
module lite_nasti_reader #(
  parameter int ID_WIDTH         = 1,
  parameter int ADDR_WIDTH       = 8,
  parameter int NASTI_DATA_WIDTH = 8,
  parameter int LITE_DATA_WIDTH  = 32,
  parameter int USER_WIDTH       = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ID_WIDTH-1:0]         lite_ar_id,
  input  logic [ADDR_WIDTH-1:0]       lite_ar_addr,
  input  logic [2:0]                  lite_ar_prot,
  input  logic [3:0]                  lite_ar_qos,
  input  logic [3:0]                  lite_ar_region,
  input  logic [USER_WIDTH-1:0]       lite_ar_user,
  input  logic                        lite_ar_valid,
  output logic                        lite_ar_ready,
  output logic [ID_WIDTH-1:0]         lite_r_id,
  output logic [LITE_DATA_WIDTH-1:0]  lite_r_data,
  output logic [1:0]                  lite_r_resp,
  output logic [USER_WIDTH-1:0]       lite_r_user,
  output logic                        lite_r_valid,
  input  logic                        lite_r_ready,
  output logic [ID_WIDTH-1:0]         nasti_ar_id,
  output logic [ADDR_WIDTH-1:0]       nasti_ar_addr,
  output logic [7:0]                  nasti_ar_len,
  output logic [2:0]                  nasti_ar_size,
  output logic [1:0]                  nasti_ar_burst,
  output logic                        nasti_ar_lock,
  output logic [3:0]                  nasti_ar_cache,
  output logic [2:0]                  nasti_ar_prot,
  output logic [3:0]                  nasti_ar_qos,
  output logic [3:0]                  nasti_ar_region,
  output logic [USER_WIDTH-1:0]       nasti_ar_user,
  output logic                        nasti_ar_valid,
  input  logic                        nasti_ar_ready,
  input  logic [ID_WIDTH-1:0]         nasti_r_id,
  input  logic [NASTI_DATA_WIDTH-1:0] nasti_r_data,
  input  logic [1:0]                  nasti_r_resp,
  input  logic                        nasti_r_last,
  input  logic [USER_WIDTH-1:0]       nasti_r_user,
  input  logic                        nasti_r_valid,
  output logic                        nasti_r_ready
);

  localparam int BUF_W = (NASTI_DATA_WIDTH < LITE_DATA_WIDTH) ? NASTI_DATA_WIDTH : LITE_DATA_WIDTH;
  localparam int BEATS = LITE_DATA_WIDTH / BUF_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SIZE  = $clog2(NASTI_DATA_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  if ((LITE_DATA_WIDTH != 32) && (LITE_DATA_WIDTH != 64)) begin : g_bad_lite
    $fatal(1, "lite_nasti_reader: LITE_DATA_WIDTH must be 32 or 64");
  end
  if ((NASTI_DATA_WIDTH < 8) || ((NASTI_DATA_WIDTH & (NASTI_DATA_WIDTH - 1)) != 0)) begin : g_bad_nasti
    $fatal(1, "lite_nasti_reader: NASTI_DATA_WIDTH must be a power of two >= 8");
  end
  if (USER_WIDTH < 1) begin : g_bad_user
    $fatal(1, "lite_nasti_reader: USER_WIDTH must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t                       state_q, state_d;
  logic [ID_WIDTH-1:0]          id_q, id_d;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic [2:0]                   prot_q, prot_d;
  logic [3:0]                   qos_q, qos_d;
  logic [3:0]                   region_q, region_d;
  logic [USER_WIDTH-1:0]        ar_user_q, ar_user_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         full_q, full_d;
  logic [LITE_DATA_WIDTH-1:0]   buf_q, buf_d;
  logic [1:0]                   resp_q, resp_d;
  logic [USER_WIDTH-1:0]        r_user_q, r_user_d;
  logic [1:0]                   acc_s;
  logic [BUF_W-1:0]             slice_s;

  // Wide NASTI: pick the lite-sized lane addressed inside the beat and align the burst address.
  if (NASTI_DATA_WIDTH > LITE_DATA_WIDTH) begin : g_wide
    localparam int LO    = $clog2(LITE_DATA_WIDTH / 8);
    localparam int SEL_W = SIZE - LO;
    localparam int LANES = NASTI_DATA_WIDTH / LITE_DATA_WIDTH;
    logic [SEL_W-1:0] sel_s;
    assign sel_s = addr_q[SIZE-1:LO];
    assign nasti_ar_addr = addr_q & ~ADDR_WIDTH'(NASTI_DATA_WIDTH / 8 - 1);
    always_comb begin
      slice_s = '0;
      for (int k = 0; k < LANES; k++) begin
        slice_s = slice_s | (nasti_r_data[k*LITE_DATA_WIDTH +: LITE_DATA_WIDTH]
                             & {LITE_DATA_WIDTH{sel_s == SEL_W'(k)}});
      end
    end
  end else begin : g_narrow
    assign slice_s       = nasti_r_data[BUF_W-1:0];
    assign nasti_ar_addr = addr_q;
  end

  // Next-state and datapath update for the single outstanding read.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    prot_d    = prot_q;
    qos_d     = qos_q;
    region_d  = region_q;
    ar_user_d = ar_user_q;
    cnt_d     = cnt_q;
    full_d    = full_q;
    buf_d     = buf_q;
    resp_d    = resp_q;
    r_user_d  = r_user_q;
    acc_s     = resp_q;
    case (state_q)
      S_IDLE: begin
        if (lite_ar_valid) begin
          id_d      = lite_ar_id;
          addr_d    = lite_ar_addr;
          prot_d    = lite_ar_prot;
          qos_d     = lite_ar_qos;
          region_d  = lite_ar_region;
          ar_user_d = lite_ar_user;
          cnt_d     = '0;
          full_d    = 1'b0;
          buf_d     = '0;
          resp_d    = 2'b00;
          state_d   = S_AR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AR: begin
        state_d = nasti_ar_ready ? S_DATA : S_AR;
      end
      S_DATA: begin
        if (nasti_r_valid && nasti_r_ready) begin
          acc_s = resp_max(resp_q, nasti_r_resp);
          if (full_q) begin
            // Surplus beat: data dropped, flagged as a slave error.
            acc_s = resp_max(acc_s, 2'b10);
          end else begin
            for (int k = 0; k < BEATS; k++) begin
              buf_d[k*BUF_W +: BUF_W] = (cnt_q == CNT_W'(k)) ? slice_s : buf_q[k*BUF_W +: BUF_W];
            end
            full_d = (cnt_q == LAST_CNT);
            cnt_d  = (cnt_q == LAST_CNT) ? cnt_q : cnt_q + CNT_W'(1);
            acc_s  = (nasti_r_last && (cnt_q != LAST_CNT)) ? resp_max(acc_s, 2'b10) : acc_s;
          end
          resp_d   = acc_s;
          r_user_d = nasti_r_user;
          state_d  = nasti_r_last ? S_RESP : S_DATA;
        end else begin
          state_d = S_DATA;
        end
      end
      S_RESP: begin
        state_d = lite_r_ready ? S_IDLE : S_RESP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      prot_q    <= 3'd0;
      qos_q     <= 4'd0;
      region_q  <= 4'd0;
      ar_user_q <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      buf_q     <= '0;
      resp_q    <= 2'b00;
      r_user_q  <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      prot_q    <= prot_d;
      qos_q     <= qos_d;
      region_q  <= region_d;
      ar_user_q <= ar_user_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      buf_q     <= buf_d;
      resp_q    <= resp_d;
      r_user_q  <= r_user_d;
    end
  end

  assign lite_ar_ready   = (state_q == S_IDLE);
  assign nasti_ar_valid  = (state_q == S_AR);
  assign lite_r_valid    = (state_q == S_RESP);
  assign nasti_r_ready   = (state_q == S_DATA) && (nasti_r_id == id_q);

  assign nasti_ar_id     = id_q;
  assign nasti_ar_len    = 8'(BEATS - 1);
  assign nasti_ar_size   = 3'(SIZE);
  assign nasti_ar_burst  = 2'b01;
  assign nasti_ar_lock   = 1'b0;
  assign nasti_ar_cache  = 4'b0001;
  assign nasti_ar_prot   = prot_q;
  assign nasti_ar_qos    = qos_q;
  assign nasti_ar_region = region_q;
  assign nasti_ar_user   = ar_user_q;

  assign lite_r_id       = id_q;
  assign lite_r_data     = buf_q;
  assign lite_r_resp     = resp_q;
  assign lite_r_user     = r_user_q;

endmodule
